// File: rtl/fpcfi.sv
// fpcfi: IEEE-754 single to signed 32-bit integer converter.
// Serial one-bit-per-cycle alignment shifter, then a rounding step and a
// result write. Latency is 2 cycles plus one cycle per alignment shift.
module fpcfi (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        stall,
    input  logic [1:0]  rnd,
    input  logic [31:0] x,
    output logic [31:0] z,
    output logic [4:0]  flags
);

    localparam logic [1:0] StReady = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StRnd   = 2'd2;
    localparam logic [1:0] StFin   = 2'd3;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [1:0]  r_rnd;
    logic [31:0] r_m;
    logic        r_guard;
    logic        r_sticky;
    logic [4:0]  r_cnt;
    logic        r_left;
    logic        r_special;
    logic        r_invalid;
    logic [31:0] r_spec_z;
    logic [31:0] r_z;
    logic [4:0]  r_flags;

    logic [7:0]  w_exp;
    logic        w_is_nan;
    logic        w_special;
    logic        w_spec_ok;
    logic [31:0] w_spec_z;
    logic        w_left;
    logic [4:0]  w_n;
    logic        w_inc;

    assign w_exp     = x[30:23];
    assign w_is_nan  = (w_exp == 8'hFF) && (x[22:0] != 23'd0);
    assign w_special = (w_exp == 8'hFF) || (w_exp >= 8'd158);
    // -2^31 is the one out-of-range-exponent value that is representable.
    assign w_spec_ok = (x == 32'hCF00_0000);
    assign w_spec_z  = (w_spec_ok || (x[31] && !w_is_nan)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign w_left    = !w_special && (w_exp > 8'd150);

    // Shift count from the exponent. The differences involved are all below 32,
    // so they are taken modulo 32 on the low exponent bits (150 mod 32 = 22).
    always_comb begin
        w_n = 5'd0;
        if (w_special || (w_exp == 8'd150)) begin
            w_n = 5'd0;
        end else if (w_exp > 8'd150) begin
            w_n = w_exp[4:0] - 5'd22;
        end else if (w_exp <= 8'd125) begin
            w_n = 5'd25;
        end else begin
            w_n = 5'd22 - w_exp[4:0];
        end
    end

    // Rounding increment from guard, sticky, lsb and sign.
    always_comb begin
        w_inc = 1'b0;
        unique case (r_rnd)
            2'b00: w_inc = r_guard & (r_sticky | r_m[0]);
            2'b01: w_inc = 1'b0;
            2'b10: w_inc = (r_guard | r_sticky) & r_sign;
            2'b11: w_inc = (r_guard | r_sticky) & ~r_sign;
            default: w_inc = 1'b0;
        endcase
    end

    // Conversion sequencer and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StReady;
            r_sign    <= 1'b0;
            r_rnd     <= 2'b00;
            r_m       <= 32'd0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_cnt     <= 5'd0;
            r_left    <= 1'b0;
            r_special <= 1'b0;
            r_invalid <= 1'b0;
            r_spec_z  <= 32'd0;
            r_z       <= 32'd0;
            r_flags   <= 5'd0;
        end else begin
            case (r_state)
                StReady: begin
                    if (run) begin
                        r_sign    <= x[31];
                        r_rnd     <= rnd;
                        r_m       <= {8'd0, (w_exp != 8'd0), x[22:0]};
                        r_guard   <= 1'b0;
                        r_sticky  <= 1'b0;
                        r_cnt     <= w_n;
                        r_left    <= w_left;
                        r_special <= w_special;
                        r_invalid <= w_special && !w_spec_ok;
                        r_spec_z  <= w_spec_z;
                        r_state   <= (w_n != 5'd0) ? StShift : StRnd;
                    end
                end
                StShift: begin
                    if (r_left) begin
                        r_m <= {r_m[30:0], 1'b0};
                    end else begin
                        r_sticky <= r_sticky | r_guard;
                        r_guard  <= r_m[0];
                        r_m      <= {1'b0, r_m[31:1]};
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= StRnd;
                    end
                end
                StRnd: begin
                    // Cannot overflow: non-special magnitudes stay below 2^31.
                    r_m     <= r_m + {31'd0, w_inc};
                    r_state <= StFin;
                end
                StFin: begin
                    r_z     <= r_special ? r_spec_z : (r_sign ? -r_m : r_m);
                    r_flags <= {r_invalid, 3'b000, (r_guard | r_sticky) & ~r_invalid};
                    r_state <= StReady;
                end
                default: r_state <= StReady;
            endcase
        end
    end

    assign stall = (r_state != StReady);
    assign z     = r_z;
    assign flags = r_flags;

endmodule

// File: doc/fpcfi.md
# fpcfi

Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter, the reverse direction of the integer-to-float converter in the float arithmetic tree. It accepts a float operand and rounding mode under the same run/stall handshake as its sibling units, and returns the rounded two's-complement integer plus exception flags. A serial one-bit-per-cycle shifter aligns the significand, so latency depends on the operand exponent. Intended for the FPU convert path and for the same text-file-driven device testbench as the other converters.

## Interface

- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  start request; sampled on a rising edge while the unit is ready.
- stall  out  1  high while a conversion is in progress.
- rnd  in  2  rounding mode:
  - 00 nearest-even
  - 01 toward zero
  - 10 toward −inf
  - 11 toward +inf
- x  in  32  IEEE single operand: sign x[31], exponent E=x[30:23], fraction f=x[22:0].
- z  out  32  signed integer result.
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}. Only bit4 (invalid) and bit0 (inexact) are ever set.

## Operation

- States: READY, SHIFT, RND, FIN. stall = (state != READY).
- READY with run=1 at a rising edge:
  - Capture sign, rnd, mantissa m = {8'b0, (E!=0), f}, guard bit r=0, sticky bit s=0.
  - Classify the operand and set the shift count n.
- Classification:
  - E == 255 (NaN/inf), or E >= 158, is special.
    - The only non-invalid special is x = 0xCF000000, which yields 0x80000000 with flags 0.
    - All others are invalid with a saturated result: NaN or positive → 0x7FFFFFFF; negative non-NaN → 0x80000000.
    - n = 0.
  - E = 151..157: left shift, n = E−150 (1..7).
  - E = 150: n = 0.
  - E = 1..149: right shift, n = min(150−E, 25).
  - E = 0: right shift, n = 25.
- Next state after capture: SHIFT if n > 0, else RND.
- SHIFT: one bit per cycle, then n decrements; exit to RND when n reaches 0.
  - Left shift: m <<= 1.
  - Right shift: s |= r; r = m[0]; m >>= 1.
- RND: compute the increment, then m = m + inc. This addition cannot overflow for non-special operands.
  - nearest-even: r & (s | m[0])
  - toward zero: 0
  - toward −inf: (r | s) & sign
  - toward +inf: (r | s) & ~sign
- FIN: write z and flags, then go to READY.
  - z = sign ? −m : m; the special result takes precedence.
  - inexact = (r | s) & ~invalid.
- z and flags hold their value from FIN until the next FIN. They are not altered by run, by stall, or by capture.
- run=0 in READY: stay in READY; no outputs change.
- run is ignored in SHIFT, RND and FIN. x and rnd need not be held after capture.
- Negative zero, and magnitudes that round to 0, give z = 0.

## Timing

- Reset (asynchronous, any state, including mid-conversion):
  - state = READY, stall = 0, z = 0, flags = 0.
  - Any conversion in progress is discarded.
  - The first capture happens on the first rising edge with rst_n high and run=1.
- stall rises immediately after the capture edge. It stays high for exactly n+2 cycles (n SHIFT + RND + FIN).
- z and flags are valid and stall is low after the FIN edge. The host samples them when it first sees stall=0 after its run edge.
- Latency range:
  - 2 cycles: specials, E = 150.
  - 27 cycles: E <= 125 and E = 0.
- Back-to-back operation: run held high in READY starts a new conversion on the edge after FIN. Zero dead cycles beyond the one READY cycle.

## Test plan

- Nearest-even tie and truncation on 1.5:
  - x=0x3FC00000, rnd=00 → z=0x00000002, flags=0x01, stall high 25 cycles.
  - Same x, rnd=01 → z=0x00000001, flags=0x01.
- All directed modes on −2.5, x=0xC0200000:
  - rnd=00 → 0xFFFFFFFE/0x01
  - rnd=10 → 0xFFFFFFFD/0x01
  - rnd=11 → 0xFFFFFFFE/0x01
- Left-shift path, x=0x4EFFFFFF → z=0x7FFFFF80, flags=0x00, stall high 9 cycles.
- Specials, each with 2 stall cycles:
  - 0xCF000000 → 0x80000000/0x00
  - 0x4F000000 → 0x7FFFFFFF/0x10
  - 0x7FC00000 → 0x7FFFFFFF/0x10
  - 0xFF800000 → 0x80000000/0x10
- Tiny and zero inputs:
  - x=0x00000001, rnd=11 → 1/0x01
  - x=0x00000001, rnd=00 → 0/0x01
  - x=0x80000001, rnd=10 → 0xFFFFFFFF/0x01
  - x=0x80000000 → 0/0x00
- Reset mid-SHIFT:
  - Assert rst_n=0 during the 1.5 conversion → stall, z, flags read 0 immediately, without a clock edge.
  - After release, x=0x41200000 with run=1 → z=0x0000000A/0x00.
